// File: rtl/comparator_2bit_monitor.sv
// Registered monitor for the 2-bit comparator relation outputs: one-hot check,
// relation encoding, trend detection, equality lock and saturating event counters.
module comparator_2bit_monitor #(
    parameter int unsigned EQ_HOLD = 4,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             A_greater_B,
    input  logic             A_equals_B,
    input  logic             A_less_B,
    input  logic             clr_counts,
    output logic [1:0]       result,
    output logic             result_valid,
    output logic             onehot_err,
    output logic             trend_change,
    output logic             eq_locked,
    output logic [CNT_W-1:0] gt_count,
    output logic [CNT_W-1:0] lt_count,
    output logic [CNT_W-1:0] eq_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int unsigned RUN_W = 4;
    localparam logic [RUN_W-1:0] HOLD    = RUN_W'(EQ_HOLD);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam logic [1:0] REL_NONE = 2'b00;
    localparam logic [1:0] REL_LT   = 2'b01;
    localparam logic [1:0] REL_GT   = 2'b10;
    localparam logic [1:0] REL_EQ   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TRACK = 2'd1,
        S_EQ    = 2'd2,
        S_LOCK  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [RUN_W-1:0] eq_run;
    logic [RUN_W-1:0] eq_run_next;
    logic [1:0]       result_next;
    logic             trend_next;
    logic [2:0]       hot_c;
    logic             onehot_c;
    logic             legal_c;
    logic             illegal_c;
    logic [1:0]       rel_c;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
    endfunction

    // Sample classification and relation encoding
    always_comb begin
        hot_c     = {A_greater_B, A_equals_B, A_less_B};
        onehot_c  = (hot_c == 3'b100) || (hot_c == 3'b010) || (hot_c == 3'b001);
        legal_c   = in_valid && onehot_c;
        illegal_c = in_valid && !onehot_c;
        rel_c     = A_greater_B ? REL_GT : (A_less_B ? REL_LT : REL_EQ);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            eq_run <= '0;
        end else begin
            state  <= state_next;
            eq_run <= eq_run_next;
        end
    end

    // Next state; outside S_IDLE, result still holds the previous legal relation
    always_comb begin
        state_next  = state;
        eq_run_next = eq_run;
        result_next = result;
        trend_next  = 1'b0;
        if (legal_c) begin
            result_next = rel_c;
            trend_next  = (state != S_IDLE) && (rel_c != result);
            if (rel_c == REL_EQ) begin
                eq_run_next = (eq_run >= HOLD) ? HOLD : eq_run + RUN_W'(1);
                state_next  = (eq_run_next == HOLD) ? S_LOCK : S_EQ;
            end else begin
                eq_run_next = '0;
                state_next  = S_TRACK;
            end
        end else if (illegal_c) begin
            state_next  = S_IDLE;
            eq_run_next = '0;
            result_next = REL_NONE;
        end
    end

    // Registered outputs and saturating counters
    always_ff @(posedge clk) begin
        if (rst) begin
            result       <= REL_NONE;
            result_valid <= 1'b0;
            onehot_err   <= 1'b0;
            trend_change <= 1'b0;
            eq_locked    <= 1'b0;
            gt_count     <= '0;
            lt_count     <= '0;
            eq_count     <= '0;
            err_count    <= '0;
        end else begin
            result       <= result_next;
            result_valid <= legal_c;
            onehot_err   <= illegal_c;
            trend_change <= trend_next;
            eq_locked    <= (state_next == S_LOCK);
            if (clr_counts) begin
                gt_count  <= '0;
                lt_count  <= '0;
                eq_count  <= '0;
                err_count <= '0;
            end else begin
                gt_count  <= sat_inc(gt_count,  legal_c && (rel_c == REL_GT));
                lt_count  <= sat_inc(lt_count,  legal_c && (rel_c == REL_LT));
                eq_count  <= sat_inc(eq_count,  legal_c && (rel_c == REL_EQ));
                err_count <= sat_inc(err_count, illegal_c);
            end
        end
    end

endmodule

// File: doc/comparator_2bit_monitor.md
# comparator_2bit_monitor

Registered downstream stage for the 2-bit structural comparator. Samples the comparator's three relation outputs under a valid strobe and checks that exactly one is asserted. Encodes the result, detects relation changes, and asserts a lock flag once A==B has held for a programmable number of samples. Also keeps saturating per-relation event counters for board-level debug and self-checking sweeps.

## Interface
- EQ_HOLD, 4: consecutive valid equal samples required for eq_locked (legal range 1..15)
- CNT_W, 8: width of each event counter
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  sample strobe; comparator outputs are sampled only when high
- A_greater_B  input  1  comparator output
- A_equals_B  input  1  comparator output
- A_less_B  input  1  comparator output
- clr_counts  input  1  synchronous clear of all four counters
- result  output  2  last legal relation: 2'b00 none, 2'b01 less, 2'b10 greater, 2'b11 equal
- result_valid  output  1  one-cycle pulse per legal sample
- onehot_err  output  1  one-cycle pulse per illegal sample (zero or more than one relation high)
- trend_change  output  1  one-cycle pulse when a legal relation differs from the previous legal relation
- eq_locked  output  1  level; equality has held for EQ_HOLD samples
- gt_count, lt_count, eq_count, err_count  output  CNT_W each  saturating event counters

## Operation
- **Legal sample:** in_valid=1 and exactly one relation input is high. Any other combination with in_valid=1 is illegal. With in_valid=0, all inputs are ignored and no state changes except clr_counts.
- **States:**
  - S_IDLE: reset, or after an error.
  - S_TRACK: last legal relation was greater or less.
  - S_EQ: equal run is below EQ_HOLD.
  - S_LOCK: equal run has reached EQ_HOLD.
- **Transitions on a legal sample:**
  - greater/less from any state -> S_TRACK; eq_run cleared.
  - equal -> eq_run increments, saturating at EQ_HOLD. Go to S_LOCK if the new eq_run equals EQ_HOLD, else S_EQ. With EQ_HOLD=1, the first equal sample goes straight to S_LOCK.
- **Illegal sample:** any state -> S_IDLE; eq_run cleared; result set to 2'b00; prev-relation memory invalidated.
- **trend_change:** fires only when a previous legal relation exists since reset or the last error, and the new one differs. Never fires on the first legal sample after S_IDLE.
- **eq_locked:** equals (state == S_LOCK).
- **Counters:**
  - Increment gt/lt/eq on the matching legal sample; err_count increments on an illegal sample.
  - Each counter saturates at 2^CNT_W-1 and never wraps.
- **clr_counts:** zeroes all counters. It wins over a same-cycle increment, so that sample is not counted. Relation logic is unaffected.
- **Width:** eq_run is 4 bits.

## Timing
- All outputs are registered. Response appears in the cycle after the sampling edge (1-cycle latency). There is no combinational path from input to output.
- Reset values:
  - state S_IDLE, eq_run 0
  - result 2'b00
  - result_valid, onehot_err, trend_change, eq_locked all 0
  - all counters 0
- rst has priority over clr_counts and in_valid. Reset asserted mid-run drops lock and counters on the next edge.
- Back-to-back in_valid every cycle is supported with no bubbles.
- result holds its value across in_valid=0 cycles. Pulse outputs are 0 in any cycle not following a sample.

## Test plan
- **Reset:** assert rst 2 cycles with inputs (1,0,0), in_valid=1 -> all outputs 0; in the first cycle after release, result=00.
- **Full sweep:** walk all 16 A/B combos through the comparator, in_valid=1 each cycle -> final gt_count=6, lt_count=6, eq_count=4, err_count=0; trend_change count matches the relation sequence.
- **Lock (EQ_HOLD=4):**
  - Four consecutive equal samples with in_valid=0 gaps between them -> eq_locked rises 1 cycle after the 4th sample.
  - A following greater sample -> eq_locked=0, trend_change=1, result=10.
- **Illegal inputs:**
  - (0,0,0) with in_valid=1 -> onehot_err pulse, err_count=1, result=00, eq_locked=0.
  - (1,1,0) -> err_count=2.
  - Next less sample -> result=01 with no trend_change.
- **Saturation and clear (CNT_W=2):**
  - 5 greater samples -> gt_count=3.
  - clr_counts in the same cycle as a less sample -> lt_count=0 next cycle.
- **Reset mid-lock:** rst while eq_locked=1 -> eq_locked=0 and counters=0 next cycle. Three subsequent equal samples do not lock.
